// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int DEPTH_LOG2_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with occupancy count; writes while full and pops while empty are ignored.
// The head byte is presented combinationally on rd_data.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESETB,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_ok) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side byte FIFO feeding a UART transmitter through a start/busy handshake.
// Optional macro UART_TX_CRLF_EN expands each LF into CR followed by LF.
//
// state   | meaning
// IDLE    | waiting for a byte and an idle transmitter
// START   | TX_DATA_EN pulse cycle
// WAIT_HI | waiting for TX_BUSY to rise, bounded by WAIT_HI_MAX cycles
// WAIT_LO | transmitter busy, waiting for TX_BUSY to fall
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEFAULT,
  parameter int WAIT_HI_MAX = 4
) (
  input  logic                  CLK,
  input  logic                  RESETB,
  input  logic [7:0]            WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVF,
  input  logic                  OVF_CLR,
  output logic [7:0]            TX_DATA,
  output logic                  TX_DATA_EN,
  input  logic                  TX_BUSY
);

  localparam int TW = (WAIT_HI_MAX > 2) ? $clog2(WAIT_HI_MAX) : 1;

  tx_state_t       state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pop;
  logic [7:0]      head;
  logic            ovf_q;
`ifdef UART_TX_CRLF_EN
  logic            cr_sent_q, cr_sent_d;
`endif

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .wr_en   (WR_EN),
    .wr_data (WR_DATA),
    .rd_en   (pop),
    .rd_data (head),
    .count   (COUNT),
    .full    (FULL),
    .empty   (EMPTY)
  );

  assign TX_DATA    = tx_data_q;
  assign TX_DATA_EN = tx_en_q;
  assign OVF        = ovf_q;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      timer_q   <= '0;
`ifdef UART_TX_CRLF_EN
      cr_sent_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      timer_q   <= timer_d;
`ifdef UART_TX_CRLF_EN
      cr_sent_q <= cr_sent_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    timer_d   = timer_q;
    pop       = 1'b0;
`ifdef UART_TX_CRLF_EN
    cr_sent_d = cr_sent_q;
`endif
    case (state_q)
      IDLE: begin
        if (!EMPTY && !TX_BUSY) begin
`ifdef UART_TX_CRLF_EN
          // CR goes out first with the LF left at the head of the FIFO.
          if (head == ASCII_LF && !cr_sent_q) begin
            tx_data_d = ASCII_CR;
            cr_sent_d = 1'b1;
          end else begin
            pop       = 1'b1;
            tx_data_d = head;
            cr_sent_d = 1'b0;
          end
`else
          pop       = 1'b1;
          tx_data_d = head;
`endif
          tx_en_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        timer_d = TW'(WAIT_HI_MAX - 1);
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (TX_BUSY)              state_d = WAIT_LO;
        else if (timer_q == '0)   state_d = IDLE;
        else                      timer_d = timer_q - TW'(1);
      end
      WAIT_LO: begin
        if (!TX_BUSY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped write wins over a simultaneous clear.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB)            ovf_q <= 1'b0;
    else if (WR_EN && FULL) ovf_q <= 1'b1;
    else if (OVF_CLR)       ovf_q <= 1'b0;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 Parameter WAIT_HI_MAX, default 4, cycles allowed for TX_BUSY to rise after a TX_DATA_EN pulse.
REQ-003 CLK  in  1  single clock; all logic on posedge CLK.
REQ-004 RESETB  in  1  reset, asynchronous, active-low.
REQ-005 WR_DATA  in  8  byte from the host.
REQ-006 WR_EN  in  1  write strobe, one byte per cycle high.
REQ-007 FULL  out  1  FIFO holds DEPTH bytes.
REQ-008 EMPTY  out  1  FIFO holds 0 bytes.
REQ-009 COUNT  out  DEPTH_LOG2+1  bytes currently stored.
REQ-010 OVF  out  1  sticky flag: a write was dropped.
REQ-011 OVF_CLR  in  1  clears OVF.
REQ-012 TX_DATA  out  8  byte to the UART transmitter.
REQ-013 TX_DATA_EN  out  1  one-cycle start pulse to the UART transmitter.
REQ-014 TX_BUSY  in  1  transmitter busy; it rises one cycle after TX_DATA_EN and falls after the stop bit.

Function
REQ-015 A write is accepted when WR_EN=1 and FULL=0; on acceptance the block stores WR_DATA at the write pointer, and the pointer wraps modulo DEPTH.
REQ-016 A write with FULL=1 is dropped and sets OVF, even if a pop occurs in the same cycle.
REQ-017 OVF_CLR=1 clears OVF; a simultaneous dropped write takes priority and leaves OVF=1.
REQ-018 COUNT is +1 on a write only, -1 on a pop only, and unchanged on a simultaneous write and pop; FULL and EMPTY derive from COUNT.
REQ-019 The FSM has the states IDLE, START, WAIT_HI and WAIT_LO.
REQ-020 In IDLE with EMPTY=0, the block pops the head byte into TX_DATA, registers TX_DATA_EN=1 and goes to START.
REQ-021 START lasts one cycle, drives TX_DATA_EN=0 on exit and goes to WAIT_HI.
REQ-022 WAIT_HI goes to WAIT_LO on TX_BUSY=1, or to IDLE after WAIT_HI_MAX cycles without TX_BUSY; the timeout discards the byte.
REQ-023 WAIT_LO goes to IDLE on TX_BUSY=0.
REQ-024 TX_DATA holds its value until the next pop.
REQ-025 Latency: for a write sampled at edge k into an empty FIFO with the FSM in IDLE, TX_DATA_EN is high from edge k+1 to edge k+2.
REQ-026 The block never issues TX_DATA_EN while TX_BUSY=1 or while the FSM is outside IDLE.
REQ-027 Back-to-back bytes: the next TX_DATA_EN rises no later than 2 cycles after TX_BUSY falls.

Reset
REQ-028 RESETB=0 immediately returns all outputs to their reset values: COUNT=0, EMPTY=1, FULL=0, OVF=0, TX_DATA=8'h00, TX_DATA_EN=0.
REQ-029 RESETB=0 immediately clears both pointers, sets the FSM to IDLE and discards stored data, including during mid-operation reset.
REQ-030 The FIFO memory array needs no reset.

Configuration
REQ-031 With macro UART_TX_CRLF_EN defined, a head byte of 8'h0A is sent as 8'h0D then 8'h0A.
REQ-032 Under UART_TX_CRLF_EN, the CR is sent without popping and a cr_sent flag is set; the LF is then popped through the normal cycle and the flag is cleared.
REQ-033 Under UART_TX_CRLF_EN, COUNT reflects FIFO bytes only.
REQ-034 Without UART_TX_CRLF_EN, all bytes are sent verbatim, no CR is inserted and no cr_sent logic exists.

Structure
REQ-035 Package uart_pkg holds the FSM state typedef, the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A, and DEPTH_LOG2_DEFAULT=4.
REQ-036 Sub-module sync_fifo holds the storage, pointers, COUNT, FULL and EMPTY; uart_tx_fifo holds the FSM, OVF logic and the CRLF logic.

Verification
REQ-037 Scenario: write 8'h41 into an empty FIFO at edge k -> TX_DATA=8'h41 and TX_DATA_EN high for exactly edges k+1 to k+2, and EMPTY=1 after edge k+1.
REQ-038 Scenario: write 3 bytes 8'h31/8'h32/8'h33 with a UART model where TX_BUSY rises 1 cycle after EN and lasts 4340 cycles -> three EN pulses in order, none while TX_BUSY=1.
REQ-039 Scenario: 17 writes with DEPTH_LOG2=4 and TX_BUSY held high -> FULL=1 and COUNT=16 after write 16, write 17 dropped and OVF=1; OVF_CLR then gives OVF=0.
REQ-040 Scenario: TX_BUSY tied low and one byte written -> return to IDLE after WAIT_HI_MAX cycles, byte discarded, EMPTY=1.
REQ-041 Scenario: RESETB pulsed low in WAIT_LO with COUNT=5 -> COUNT=0, EMPTY=1, TX_DATA_EN=0, FSM in IDLE, no EN pulse until a new write.
REQ-042 Scenario: with UART_TX_CRLF_EN, write 8'h0A -> EN pulses carry 8'h0D then 8'h0A; without the macro -> one pulse carrying 8'h0A.
